lsu: RTL and testbench
======================

# lsu

Load/store unit between the single-cycle RISC-V core and data memory. Takes a load/store request from the datapath (ALU result as address, rs2 as store data, funct3 as width), steers it onto a word-wide, byte-enabled memory port with a req/ack handshake, and returns the sign- or zero-extended load result to register writeback. While the access is in flight it holds `busy` high so the core freezes the program counter. It replaces direct datapath-to-RAM wiring so multi-cycle memories can be attached.

## Interface
- n, 32, data/address width; byte lanes = n/8 (n = 32 only supported)
- TIMEOUT, 15, max cycles in ACCESS without `mem_ack` before abort (≥1)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req  in  1  memory instruction valid; held by core until `done`
- we  in  1  1 = store, 0 = load
- funct3  in  3  instr[14:12] width/extension code
- addr  in  n  byte address (ALU output)
- wdata  in  n  store data (rs2)
- rdata  out  n  extended load result, registered
- done  out  1  one-cycle pulse: access complete, `rdata` valid
- busy  out  1  stall request to core
- err  out  1  one-cycle pulse with `done` on timeout
- misalign  out  1  one-cycle pulse on misaligned request (macro-gated)
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  n  word address ({addr[n-1:2],2'b00}), registered
- mem_be  out  4  byte enables, registered
- mem_wdata  out  n  lane-replicated store data, registered
- mem_rdata  in  n  memory read word, valid with `mem_ack`
- mem_ack  in  1  memory completion

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: `req`=1 at edge → latch `we`, `funct3`, `addr[1:0]`, register mem_* outputs → ACCESS. `mem_ack` ignored.
- ACCESS: `mem_req`=1, mem_* stable. `mem_ack`=1 → capture extended `mem_rdata` into `rdata` (loads only; stores leave `rdata` unchanged) → DONE. Counter reaching TIMEOUT without ack → `rdata`=0, DONE with `err`.
- DONE: `done`=1 one cycle, `mem_req`=0 → IDLE unconditionally; `req` ignored this cycle.
- `busy` = (state==ACCESS) | (state==IDLE & req). Low in DONE so the core advances on that edge.
- Byte lanes, little-endian, k=addr[1:0]:
  - byte (000/100): be = 1<<k; store data {4{wdata[7:0]}}; load lane k.
  - half (001/101): be = 0011 (k[1]=0) or 1100; store data {2{wdata[15:0]}}.
  - word (010) and illegal codes (011,110,111): be = 1111, full word.
  - 000/001 sign-extend; 100/101 zero-extend.
- Misaligned: half with k[0]=1, word with k≠0.
- Reset (`reset`=0 at edge), any state: → IDLE; all outputs 0 next cycle, counter cleared; in-flight access abandoned, late `mem_ack` ignored.

## Timing
- Zero-wait memory (ack in first ACCESS cycle): req seen cycle 0, `mem_req` cycle 1, `done`/`rdata` cycle 2 → 3-cycle memory instruction.
- Each wait cycle adds one; worst case 2+TIMEOUT cycles.
- `rdata` holds until the next completed load.
- Timeout counter is ⌈log2(TIMEOUT+1)⌉ bits, clears on ACCESS entry, saturates.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned request goes IDLE→DONE directly (no `mem_req`), `misalign`=1 with `done`, `rdata` unchanged, no memory write.
- Undefined: `misalign` tied 0; address low bits forced to natural alignment (half clears bit 0, word clears bits 1:0) and access proceeds.

## Structure
- `lsu_pkg`: state enum, funct3 width codes (LB, LH, LW, LBU, LHU, SB, SH, SW), lane-count constant.
- Sub-module `lsu_lane`: combinational steering — be/store replication from (funct3, k) and load extraction/extension from (funct3, k, mem_rdata). FSM, counter and registers stay in `lsu`.

## Test plan
- lb at 0x103, zero-wait, mem_rdata=0x80FF_FF00 → mem_be=1000, mem_addr=0x100, done cycle 2, rdata=0xFFFF_FF80.
- lhu at 0x202, two wait cycles, mem_rdata=0xBEEF_1234 → mem_be=1100, done cycle 4, rdata=0x0000_BEEF, busy high cycles 0–3.
- sb at 0x301, wdata=0x1234_56AB → mem_we=1, mem_be=0010, mem_wdata=0xABAB_ABAB, rdata unchanged.
- No ack, TIMEOUT=15 → mem_req high 15 cycles, then done+err, rdata=0, return to IDLE.
- lw at 0x402: macro on → no mem_req, done+misalign next cycle; macro off → mem_addr=0x400, mem_be=1111, normal completion.
- reset=0 during ACCESS with ack arriving one cycle later → next cycle mem_req=0, busy=0, done never pulses.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 width
// codes, lane count and the alignment check.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam int LANES = 4;

   // Illegal codes behave as full-word accesses, so they need word alignment too.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] k);
      case (f3)
         LB, LBU: return 1'b0;
         LH, LHU: return k[0];
         default: return (k != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane steering: store byte enables and data replication,
// plus load lane extraction with sign/zero extension.
module lsu_lane
   import lsu_pkg::*;
#(
   parameter int n = 32
) (
   input  logic [2:0]       st_funct3,
   input  logic [1:0]       st_k,
   input  logic [n-1:0]     wdata,
   input  logic [2:0]       ld_funct3,
   input  logic [1:0]       ld_k,
   input  logic [n-1:0]     mem_rdata,
   output logic [LANES-1:0] be,
   output logic [n-1:0]     st_data,
   output logic [n-1:0]     ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      be      = 4'b1111;
      st_data = wdata;
      case (st_funct3)
         LB, LBU: begin
            be      = 4'b0001 << st_k;
            st_data = {4{wdata[7:0]}};
         end
         LH, LHU: begin
            be      = st_k[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = mem_rdata[{ld_k, 3'b000} +: 8];
      ld_half = ld_k[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (ld_funct3)
         LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
         LH:      ld_data = {{16{ld_half[15]}}, ld_half};
         LBU:     ld_data = {24'h0, ld_byte};
         LHU:     ld_data = {16'h0, ld_half};
         default: ld_data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: req/ack memory port with timeout and registered load result.
// LSU_MISALIGN_TRAP_EN: misaligned requests complete at once with misalign set.
module lsu
   import lsu_pkg::*;
#(
   parameter int n       = 32,
   parameter int TIMEOUT = 15
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           req,
   input  logic           we,
   input  logic [2:0]     funct3,
   input  logic [n-1:0]   addr,
   input  logic [n-1:0]   wdata,
   output logic [n-1:0]   rdata,
   output logic           done,
   output logic           busy,
   output logic           err,
   output logic           misalign,
   output logic           mem_req,
   output logic           mem_we,
   output logic [n-1:0]   mem_addr,
   output logic [3:0]     mem_be,
   output logic [n-1:0]   mem_wdata,
   input  logic [n-1:0]   mem_rdata,
   input  logic           mem_ack
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      f3_q;
   logic [1:0]      k_q;
   logic [1:0]      k_al;
   logic            trap;
   logic [3:0]      be;
   logic [n-1:0]    st_data;
   logic [n-1:0]    ld_data;

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = is_misaligned(funct3, addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   // Without the trap, low address bits are forced to the access's natural alignment.
   always_comb begin
      k_al = addr[1:0];
      case (funct3)
         LB, LBU: ;
         LH, LHU: k_al[0] = 1'b0;
         default: k_al = 2'b00;
      endcase
   end

   lsu_lane #(.n(n)) u_lane (
      .st_funct3 (funct3),
      .st_k      (k_al),
      .wdata     (wdata),
      .ld_funct3 (f3_q),
      .ld_k      (k_q),
      .mem_rdata (mem_rdata),
      .be        (be),
      .st_data   (st_data),
      .ld_data   (ld_data)
   );

   assign busy = (state == S_ACCESS) | ((state == S_IDLE) & req);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         f3_q      <= '0;
         k_q       <= '0;
         rdata     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         misalign  <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         misalign <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  if (trap) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     misalign <= 1'b1;
                  end else begin
                     state     <= S_ACCESS;
                     cnt       <= '0;
                     f3_q      <= funct3;
                     k_q       <= k_al;
                     mem_req   <= 1'b1;
                     mem_we    <= we;
                     mem_addr  <= {addr[n-1:2], 2'b00};
                     mem_be    <= be;
                     mem_wdata <= st_data;
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ack) begin
                  state   <= S_DONE;
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  if (!mem_we) rdata <= ld_data;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state   <= S_DONE;
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  err     <= 1'b1;
                  rdata   <= '0;
               end else if (cnt != CW'(TIMEOUT)) begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, hand-written timeout/reset/alignment
// sequences and randomized accesses against an arithmetic reference model.
module tb_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP_ON = 1'b1;
`else
   localparam bit TRAP_ON = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  funct3 = 3'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        done, busy, err, misalign;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [31:0] cur_rd = '0;
   logic [31:0] exp_q[$];

   lsu #(.n(32), .TIMEOUT(15)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .we        (we),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .done      (done),
      .busy      (busy),
      .err       (err),
      .misalign  (misalign),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  f3;
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] mrd;
      int          waits;
      logic [3:0]  xbe;
      logic [31:0] xaddr;
      logic [31:0] xwd;
      logic [31:0] xrd;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: access size, naturally aligned offset, replicated store data, extended load.
   function automatic void model(input logic [2:0] f3, input logic w, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] mrd,
                                 input logic [31:0] prev, output logic trap,
                                 output logic [3:0] xbe, output logic [31:0] xaddr,
                                 output logic [31:0] xwd, output logic [31:0] xrd);
      int sz, off;
      logic [31:0] v, mask;
      sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off = int'(a % 4);
      trap = TRAP_ON && ((off % sz) != 0);
      off = off - (off % sz);
      xbe = 4'(((1 << sz) - 1) << off);
      xaddr = a - (a % 4);
      xwd = (sz == 1) ? wd[7:0] * 32'h0101_0101 : (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
      v = mrd >> (8 * off);
      if (sz < 4) begin
         mask = (32'h1 << (8 * sz)) - 32'h1;
         v = v & mask;
         if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
      end
      xrd = (trap || w) ? prev : v;
   endfunction

   task automatic do_access(input string name, input logic [2:0] f3, input logic w,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                            input int waits, input logic trap, input logic [3:0] xbe,
                            input logic [31:0] xaddr, input logic [31:0] xwd,
                            input logic [31:0] xrd);
      exp_q.push_back(xrd);
      @(negedge clock);
      req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
      #1 chk({name, " busy c0"}, 32'(busy), 32'd1);
      if (trap) begin
         @(negedge clock);
         req = 1'b0;
         #1;
         chk({name, " done"}, 32'(done), 32'd1);
         chk({name, " misalign"}, 32'(misalign), 32'd1);
         chk({name, " mem_req"}, 32'(mem_req), 32'd0);
         chk({name, " busy"}, 32'(busy), 32'd0);
         chk({name, " rdata"}, rdata, exp_q.pop_front());
      end else begin
         for (int c = 0; c <= waits; c++) begin
            @(negedge clock);
            if (c == waits) begin
               mem_ack = 1'b1;
               mem_rdata = mrd;
            end
            #1;
            chk({name, " mem_req"}, 32'(mem_req), 32'd1);
            chk({name, " busy"}, 32'(busy), 32'd1);
            chk({name, " done early"}, 32'(done), 32'd0);
            chk({name, " mem_addr"}, mem_addr, xaddr);
            chk({name, " mem_be"}, 32'(mem_be), 32'(xbe));
            chk({name, " mem_we"}, 32'(mem_we), 32'(w));
            chk({name, " mem_wdata"}, mem_wdata, xwd);
         end
         @(negedge clock);
         mem_ack = 1'b0;
         mem_rdata = 32'h5A5A_5A5A;
         req = 1'b0;
         #1;
         chk({name, " done"}, 32'(done), 32'd1);
         chk({name, " err"}, 32'(err), 32'd0);
         chk({name, " misalign"}, 32'(misalign), 32'd0);
         chk({name, " mem_req off"}, 32'(mem_req), 32'd0);
         chk({name, " busy off"}, 32'(busy), 32'd0);
         chk({name, " rdata"}, rdata, exp_q.pop_front());
      end
      cur_rd = xrd;
   endtask

   initial begin
      logic        t;
      logic [3:0]  xbe;
      logic [31:0] xa, xwd, xrd, a, wd, mrd;
      logic [2:0]  f3;
      logic        w;

      tbl[0] = '{LB_C(), 1'b0, 32'h0000_0103, 32'h1122_3344, 32'h80FF_FF00, 0,
                 4'b1000, 32'h0000_0100, 32'h4444_4444, 32'hFFFF_FF80};
      tbl[1] = '{3'b100 | 3'b001, 1'b0, 32'h0000_0202, 32'h0, 32'hBEEF_1234, 2,
                 4'b1100, 32'h0000_0200, 32'h0, 32'h0000_BEEF};
      tbl[2] = '{3'b000, 1'b1, 32'h0000_0301, 32'h1234_56AB, 32'hDEAD_BEEF, 0,
                 4'b0010, 32'h0000_0300, 32'hABAB_ABAB, 32'h0000_BEEF};
      tbl[3] = '{3'b001, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1,
                 4'b1100, 32'h0000_0000, 32'h0, 32'hFFFF_8001};
      tbl[4] = '{3'b010, 1'b0, 32'h0000_07F0, 32'h0, 32'hCAFE_F00D, 3,
                 4'b1111, 32'h0000_07F0, 32'h0, 32'hCAFE_F00D};
      tbl[5] = '{3'b001, 1'b1, 32'h0000_00A0, 32'h0000_9876, 32'h0, 0,
                 4'b0011, 32'h0000_00A0, 32'h9876_9876, 32'hCAFE_F00D};
      tbl[6] = '{3'b010, 1'b1, 32'h0000_00C4, 32'hA5A5_1234, 32'h0, 1,
                 4'b1111, 32'h0000_00C4, 32'hA5A5_1234, 32'hCAFE_F00D};
      tbl[7] = '{3'b100, 1'b0, 32'h0000_0011, 32'h0, 32'h0000_F000, 0,
                 4'b0010, 32'h0000_0010, 32'h0, 32'h0000_00F0};
      tbl[8] = '{3'b110, 1'b0, 32'h0000_0020, 32'h0, 32'h1357_9BDF, 0,
                 4'b1111, 32'h0000_0020, 32'h0, 32'h1357_9BDF};

      // Reset state
      repeat (3) @(negedge clock);
      #1;
      chk("rst rdata", rdata, 32'h0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst misalign", 32'(misalign), 32'd0);
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_be", 32'(mem_be), 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      @(negedge clock);
      reset = 1'b1;

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         do_access($sformatf("vec%0d", i), tbl[i].f3, tbl[i].w, tbl[i].a, tbl[i].wd,
                   tbl[i].mrd, tbl[i].waits, 1'b0, tbl[i].xbe, tbl[i].xaddr,
                   tbl[i].xwd, tbl[i].xrd);
      end

      // lw at a misaligned address
      if (TRAP_ON)
         do_access("lw402", 3'b010, 1'b0, 32'h0000_0402, 32'h0, 32'h0BAD_F00D, 0, 1'b1,
                   4'b0000, 32'h0, 32'h0, 32'h1357_9BDF);
      else
         do_access("lw402", 3'b010, 1'b0, 32'h0000_0402, 32'h0, 32'h0BAD_F00D, 0, 1'b0,
                   4'b1111, 32'h0000_0400, 32'h0, 32'h0BAD_F00D);

      // Timeout: no ack for 15 ACCESS cycles
      @(negedge clock);
      req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0500;
      mem_rdata = 32'hFFFF_FFFF;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clock);
         #1;
         chk($sformatf("tmo mem_req c%0d", c), 32'(mem_req), 32'd1);
         chk($sformatf("tmo done c%0d", c), 32'(done), 32'd0);
      end
      @(negedge clock);
      req = 1'b0;
      #1;
      chk("tmo done", 32'(done), 32'd1);
      chk("tmo err", 32'(err), 32'd1);
      chk("tmo rdata", rdata, 32'h0);
      chk("tmo mem_req", 32'(mem_req), 32'd0);
      @(negedge clock);
      #1;
      chk("tmo done after", 32'(done), 32'd0);
      chk("tmo err after", 32'(err), 32'd0);
      chk("tmo busy after", 32'(busy), 32'd0);
      cur_rd = 32'h0;

      // Load that yields a nonzero rdata, then reset mid-access with a late ack
      do_access("lw pre", 3'b010, 1'b0, 32'h0000_0604, 32'h0, 32'h7777_0001, 0, 1'b0,
                4'b1111, 32'h0000_0604, 32'h0, 32'h7777_0001);
      @(negedge clock);
      req = 1'b1; funct3 = 3'b010; we = 1'b0; addr = 32'h0000_0600;
      @(negedge clock);
      #1 chk("rst mid mem_req", 32'(mem_req), 32'd1);
      reset = 1'b0; req = 1'b0;
      @(negedge clock);
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("rst mid mem_req off", 32'(mem_req), 32'd0);
      chk("rst mid busy", 32'(busy), 32'd0);
      chk("rst mid done", 32'(done), 32'd0);
      chk("rst mid rdata", rdata, 32'h0);
      @(negedge clock);
      mem_ack = 1'b0;
      #1;
      chk("rst late ack done", 32'(done), 32'd0);
      chk("rst late ack mem_req", 32'(mem_req), 32'd0);
      chk("rst late ack rdata", rdata, 32'h0);
      cur_rd = 32'h0;

      // Randomized accesses against the reference model
      for (int i = 0; i < 60; i++) begin
         w = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: f3 = 3'b000;
            1: f3 = 3'b001;
            2: f3 = 3'b010;
            3: f3 = w ? 3'b000 : 3'b100;
            default: f3 = w ? 3'b001 : 3'b101;
         endcase
         a = $urandom;
         wd = $urandom;
         mrd = $urandom;
         model(f3, w, a, wd, mrd, cur_rd, t, xbe, xa, xwd, xrd);
         do_access($sformatf("rnd%0d", i), f3, w, a, wd, mrd, $urandom_range(0, 3), t,
                   xbe, xa, xwd, xrd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   function automatic logic [2:0] LB_C();
      return 3'b000;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
